// File: rtl/arith_dp_pkg.sv
// -----------------------------------------------------------------------------
// arith_dp_pkg
// Shared definitions for the pipelined arithmetic datapath:
//   - opcode encodings ({sel_zero, invert, carry_in})
//   - opcode bit positions
//   - sat_limit(): signed saturation limits for an n-bit result (n <= 64)
// -----------------------------------------------------------------------------
package arith_dp_pkg;

  // Opcode encodings. 3'b111 behaves like OP_PASS (A + ~0 + 1 == A).
  localparam logic [2:0] OP_ADD  = 3'b000;  // A + B
  localparam logic [2:0] OP_ADDC = 3'b001;  // A + B + 1
  localparam logic [2:0] OP_SUBB = 3'b010;  // A - B - 1
  localparam logic [2:0] OP_SUB  = 3'b011;  // A - B
  localparam logic [2:0] OP_PASS = 3'b100;  // A
  localparam logic [2:0] OP_INC  = 3'b101;  // A + 1
  localparam logic [2:0] OP_DEC  = 3'b110;  // A - 1

  // Opcode bit positions.
  localparam int OP_SEL_ZERO = 2;
  localparam int OP_INV      = 1;
  localparam int OP_CIN      = 0;

  // Widest result the saturation helper can describe.
  localparam int SAT_MAX_W = 64;

  // Signed saturation limit for an n-bit two's-complement value, returned
  // right-aligned in a SAT_MAX_W vector: neg=1 gives 100..0, neg=0 gives 011..1.
  function automatic logic [SAT_MAX_W-1:0] sat_limit(input int unsigned n,
                                                     input logic        neg);
    logic [SAT_MAX_W-1:0] lim;
    lim        = '0;
    lim[n-1]   = 1'b1;
    if (!neg) begin
      lim = lim - {{(SAT_MAX_W-1){1'b0}}, 1'b1};
    end
    return lim;
  endfunction

endpackage

// File: rtl/arith_dp_core.sv
// -----------------------------------------------------------------------------
// arith_dp_core
// Purely combinational arithmetic, split into two independently wired phases
// so the parent can place pipeline registers between them.
//   Phase X (operand mux + adder):
//     a, b     in  N  signed operands
//     opcode   in  3  [2] B=0, [1] invert, [0] carry-in
//     s        out N  raw sum
//     co       out 1  unsigned carry-out
//     ov       out 1  signed overflow
//   Phase Y (saturation + flags):
//     y_s      in  N  raw sum from phase X (possibly registered)
//     y_ov     in  1  overflow from phase X (possibly registered)
//     y        out N  final result
//     z, n     out 1  y == 0, y[N-1]
// -----------------------------------------------------------------------------
module arith_dp_core
  import arith_dp_pkg::*;
#(
  parameter int N   = 16,
  parameter bit SAT = 1'b0
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   opcode,
  output logic [N-1:0] s,
  output logic         co,
  output logic         ov,
  input  logic [N-1:0] y_s,
  input  logic         y_ov,
  output logic [N-1:0] y,
  output logic         z,
  output logic         n
);

  localparam logic [N-1:0] MAX_POS = N'(sat_limit(N, 1'b0));
  localparam logic [N-1:0] MAX_NEG = N'(sat_limit(N, 1'b1));

  // ---------------- Phase X ----------------
  logic [N-1:0] m1;
  logic [N-1:0] m2;
  logic [N:0]   sum;

  // NOTE: every always_comb output is assigned unconditionally before any
  // branch, so no path leaves a variable holding its old value (no latch).
  always_comb begin
    m1  = opcode[OP_SEL_ZERO] ? '0 : b;
    m2  = opcode[OP_INV] ? ~m1 : m1;
    sum = {1'b0, a} + {1'b0, m2} + {{N{1'b0}}, opcode[OP_CIN]};
  end

  assign s  = sum[N-1:0];
  assign co = sum[N];
  assign ov = (a[N-1] == m2[N-1]) && (sum[N-1] != a[N-1]);

  // ---------------- Phase Y ----------------
  // On overflow the raw sum's sign is the opposite of A's sign, so the
  // saturation direction is recovered from y_s alone and A need not be
  // carried through the phase-X register.
  always_comb begin
    y = y_s;
    if (SAT && y_ov) begin
      y = y_s[N-1] ? MAX_POS : MAX_NEG;
    end
  end

  assign z = (y == '0);
  assign n = y[N-1];

endmodule

// File: rtl/arith_datapath_pipe.sv
// -----------------------------------------------------------------------------
// arith_datapath_pipe
// Parametrised arithmetic datapath (operand-B mux, optional inversion,
// carry-in adder) with 0..3 register stages, valid/ready handshake with a
// whole-pipeline stall, signed overflow detection, optional saturation,
// zero/negative flags and a saturating overflow event counter.
//
// Parameters: N (width, >=2, <=64), PIPE (0..3), SAT (1 = saturate), CNT_W.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand beat handshake
//   A, B, opcode          operands and {sel_zero, invert, carry_in}
//   out_valid / out_ready result handshake
//   Y, co, ov, z, n       result, carry-out, overflow (pre-sat), flags
//   ov_cnt                delivered results with ov=1, holds at all-ones
//
// Stage placement: PIPE=3 input reg | X | reg | Y | reg
//                  PIPE=2           X | reg | Y | reg
//                  PIPE=1           X       Y | reg
//                  PIPE=0           X       Y          (combinational)
// -----------------------------------------------------------------------------
module arith_datapath_pipe
  import arith_dp_pkg::*;
#(
  parameter int N     = 16,
  parameter int PIPE  = 2,
  parameter bit SAT   = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     Y,
  output logic             co,
  output logic             ov,
  output logic             z,
  output logic             n,
  output logic [CNT_W-1:0] ov_cnt
);

  // A stall freezes every stage at once, so nothing can be overwritten or
  // dropped while the head result waits for the consumer.
  logic stall;
  assign stall = out_valid && !out_ready;

  // Phase X inputs / outputs.
  logic [N-1:0] x_a;
  logic [N-1:0] x_b;
  logic [2:0]   x_op;
  logic         x_v;
  logic [N-1:0] x_s;
  logic         x_co;
  logic         x_ov;

  // Phase Y inputs / outputs.
  logic [N-1:0] y_s;
  logic         y_co;
  logic         y_ov;
  logic         y_v;
  logic [N-1:0] f_y;
  logic         f_z;
  logic         f_n;

  arith_dp_core #(
    .N   (N),
    .SAT (SAT)
  ) u_core (
    .a      (x_a),
    .b      (x_b),
    .opcode (x_op),
    .s      (x_s),
    .co     (x_co),
    .ov     (x_ov),
    .y_s    (y_s),
    .y_ov   (y_ov),
    .y      (f_y),
    .z      (f_z),
    .n      (f_n)
  );

  // ---------------- Optional input register ----------------
  if (PIPE == 3) begin : g_in_reg
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [2:0]   op_q;
    logic         v_q;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
      end else if (!stall) begin
        v_q <= in_valid;
      end
    end

    // NOTE: payload registers have no reset; the stage valid bit already marks
    // them as meaningless after reset.
    always_ff @(posedge clk) begin
      if (!stall) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= opcode;
      end
    end

    assign x_a  = a_q;
    assign x_b  = b_q;
    assign x_op = op_q;
    assign x_v  = v_q;
  end else begin : g_in_pass
    assign x_a  = A;
    assign x_b  = B;
    assign x_op = opcode;
    assign x_v  = in_valid;
  end

  // ---------------- Optional register after phase X ----------------
  if (PIPE >= 2) begin : g_x_reg
    logic [N-1:0] s_q;
    logic         co_q;
    logic         ov_q;
    logic         v_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
      end else if (!stall) begin
        v_q <= x_v;
      end
    end

    always_ff @(posedge clk) begin
      if (!stall) begin
        s_q  <= x_s;
        co_q <= x_co;
        ov_q <= x_ov;
      end
    end

    assign y_s  = s_q;
    assign y_co = co_q;
    assign y_ov = ov_q;
    assign y_v  = v_q;
  end else begin : g_x_pass
    assign y_s  = x_s;
    assign y_co = x_co;
    assign y_ov = x_ov;
    assign y_v  = x_v;
  end

  // ---------------- Output register after phase Y ----------------
  if (PIPE >= 1) begin : g_y_reg
    logic [N-1:0] y_q;
    logic         co_q;
    logic         ov_q;
    logic         z_q;
    logic         n_q;
    logic         v_q;

    // Visible outputs are cleared on reset so the consumer never sees stale
    // results from discarded beats.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q  <= 1'b0;
        y_q  <= '0;
        co_q <= 1'b0;
        ov_q <= 1'b0;
        z_q  <= 1'b0;
        n_q  <= 1'b0;
      end else if (!stall) begin
        v_q  <= y_v;
        y_q  <= f_y;
        co_q <= y_co;
        ov_q <= y_ov;
        z_q  <= f_z;
        n_q  <= f_n;
      end
    end

    assign out_valid = v_q;
    assign Y         = y_q;
    assign co        = co_q;
    assign ov        = ov_q;
    assign z         = z_q;
    assign n         = n_q;
    assign in_ready  = !stall;
  end else begin : g_y_pass
    assign out_valid = y_v;
    assign Y         = f_y;
    assign co        = y_co;
    assign ov        = y_ov;
    assign z         = f_z;
    assign n         = f_n;
    assign in_ready  = out_ready;
  end

  // ---------------- Overflow event counter ----------------
  // Counts only on a delivery handshake, so a result held by backpressure is
  // counted once, in the cycle it is finally taken.
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready && ov && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign ov_cnt = cnt_q;

endmodule
